// File: rtl/firebird7_in_gate1_tessent_tdr_src_w19_if.sv
// IJTAG scan-control and mux-control bundle between host/SIB side and the TDR.
// Latency: none (wires only).
// Backpressure: none; scan enables are qualified by ijtag_sel inside the TDR.
interface firebird7_in_gate1_tessent_tdr_src_w19_if #(
  parameter int WIDTH = 19
);
  logic             ijtag_sel;
  logic             ijtag_ce;
  logic             ijtag_se;
  logic             ijtag_ue;
  logic             ijtag_si;
  logic             ijtag_so;
  logic [WIDTH-1:0] capture_data;
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_data_in;
  logic             update_strobe;

  // Host side: drives scan controls and mux readback, observes TDR outputs.
  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data,
    input  ijtag_so, ijtag_select, ijtag_data_in, update_strobe
  );

  // TDR side.
  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data,
    output ijtag_so, ijtag_select, ijtag_data_in, update_strobe
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_src_w19.sv
// IJTAG TDR driving select/data controls of a WIDTH-bit ijtag/functional mux.
// Latency: WIDTH+1 shifts + 1 update cycle; mux sees new value the cycle after update.
// Backpressure: none; all enables ignored while ijtag_sel is low (state holds).
module firebird7_in_gate1_tessent_tdr_src_w19 #(
  parameter int               WIDTH        = 19,   // must be >= 1
  parameter logic [WIDTH-1:0] DATA_RESET   = '0,
  parameter logic             SELECT_RESET = 1'b0  // 0 selects the functional path
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_tdr_src_w19_if.slave bus
);

  // sr[WIDTH] is the select bit, sr[WIDTH-1:0] the data field.
  logic [WIDTH:0]   sr;
  logic             upd_sel;
  logic [WIDTH-1:0] upd_data;
  logic             strobe;
  logic             do_capture;
  logic             do_shift;
  logic             do_update;

  // ce beats se beats ue; nothing happens unless this TDR is on the scan path.
  assign do_capture = bus.ijtag_sel & bus.ijtag_ce;
  assign do_shift   = bus.ijtag_sel & ~bus.ijtag_ce & bus.ijtag_se;
  assign do_update  = bus.ijtag_sel & ~bus.ijtag_ce & ~bus.ijtag_se & bus.ijtag_ue;

  // Shift/capture register: capture loads readback with the current select on top,
  // shift moves LSB-first toward so with new bits entering at the select end.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr <= '0;
    end else if (do_capture) begin
      sr <= {upd_sel, bus.capture_data};
    end else if (do_shift) begin
      sr <= {bus.ijtag_si, sr[WIDTH:1]};
    end
  end

  // Update registers: the only state the mux sees, so they move only on update.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_sel  <= SELECT_RESET;
      upd_data <= DATA_RESET;
    end else if (do_update) begin
      upd_sel  <= sr[WIDTH];
      upd_data <= sr[WIDTH-1:0];
    end
  end

  // Strobe follows each accepted update by one cycle; back-to-back updates stay high.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      strobe <= 1'b0;
    end else begin
      strobe <= do_update;
    end
  end

  // so is unqualified by ijtag_sel; the host selects among TDR scan outputs.
  assign bus.ijtag_so       = sr[0];
  assign bus.ijtag_select   = upd_sel;
  assign bus.ijtag_data_in  = upd_data;
  assign bus.update_strobe  = strobe;

endmodule
